// File: rtl/apb_splitter_pkg.sv
// Shared types and helpers for the APB splitter: FSM states, PPROT width, window decode.
package apb_pkg;

  localparam int PROT_W = 3;
  localparam int DEC_W  = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2,
    RESP     = 2'd3
  } state_e;

  // Operands are zero-extended AW-bit values, so the subtraction never wraps once addr >= base.
  function automatic logic decode_hit(input logic [DEC_W-1:0] addr,
                                      input logic [DEC_W-1:0] base,
                                      input logic [DEC_W-1:0] size);
    logic hit_v;
    if (addr >= base) begin
      hit_v = ((addr - base) < size);
    end else begin
      hit_v = 1'b0;
    end
    return hit_v;
  endfunction

endpackage

// File: rtl/apb_splitter_addr_decoder.sv
// Combinational window decoder: NS base/size windows in, one-hot hit (lowest index wins) plus miss flag out.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int AW = 32,
  parameter int NS = 4
) (
  input  logic [AW-1:0]    addr,
  input  logic [NS*AW-1:0] base,
  input  logic [NS*AW-1:0] size,
  output logic [NS-1:0]    hit,
  output logic             miss
);

  logic [NS-1:0] raw_s;

  // Per-window match, independent of the other windows
  always_comb begin
    raw_s = {NS{1'b0}};
    for (int i = 0; i < NS; i++) begin
      raw_s[i] = decode_hit(DEC_W'(addr), DEC_W'(base[i*AW +: AW]), DEC_W'(size[i*AW +: AW]));
    end
  end

  // Keep only the lowest set bit so overlapping windows resolve to the lowest index
  always_comb begin
    hit  = raw_s & (~raw_s + NS'(1'b1));
    miss = ~|raw_s;
  end

endmodule

// File: rtl/apb_splitter.sv
// APB 1-to-NS splitter with registered downstream/upstream outputs.
// Optional access-phase timeout enabled by defining APB_SPLITTER_TIMEOUT_EN.
module apb_splitter
  import apb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int NS     = 4,
  parameter int AM     = 0,
  parameter int TO_CYC = 255
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [NS*AW-1:0]    cfg_BASE_ADDR,
  input  logic [NS*AW-1:0]    cfg_SIZE,
  input  logic [AW-1:0]       s_PADDR,
  input  logic                s_PWRITE,
  input  logic [DW-1:0]       s_PWDATA,
  input  logic                s_PSEL,
  input  logic                s_PENABLE,
  input  logic [PROT_W-1:0]   s_PPROT,
  input  logic [DW/8-1:0]     s_PSTRB,
  output logic                s_PREADY,
  output logic [DW-1:0]       s_PRDATA,
  output logic                s_PSLVERR,
  output logic [AW-1:0]       m_PADDR,
  output logic                m_PWRITE,
  output logic [DW-1:0]       m_PWDATA,
  output logic                m_PENABLE,
  output logic [PROT_W-1:0]   m_PPROT,
  output logic [DW/8-1:0]     m_PSTRB,
  output logic [NS-1:0]       m_PSEL,
  input  logic [NS-1:0]       m_PREADY,
  input  logic [NS*DW-1:0]    m_PRDATA,
  input  logic [NS-1:0]       m_PSLVERR
);

  if (TO_CYC < 1 || NS < 1 || NS > 16 || (DW % 8) != 0) begin : g_bad_cfg
    $error("apb_splitter: illegal parameter set");
  end

  state_e        state_r;
  logic [NS-1:0] dec_hit_s;
  logic          dec_miss_s;
  logic [AW-1:0] base_sel_s;
  logic [DW-1:0] sel_rdata_s;
  logic          sel_ready_s;
  logic          sel_slverr_s;

`ifdef APB_SPLITTER_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYC + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYC - 1);
  logic [TOW-1:0] to_cnt_r;
`endif

  apb_addr_decoder #(.AW(AW), .NS(NS)) u_dec (
    .addr (s_PADDR),
    .base (cfg_BASE_ADDR),
    .size (cfg_SIZE),
    .hit  (dec_hit_s),
    .miss (dec_miss_s)
  );

  // Base of the decoded window (hit vector is one-hot), used for offset addressing
  always_comb begin
    base_sel_s = {AW{1'b0}};
    for (int i = 0; i < NS; i++) begin
      base_sel_s = base_sel_s | (cfg_BASE_ADDR[i*AW +: AW] & {AW{dec_hit_s[i]}});
    end
  end

  // Return path muxed by the registered one-hot select
  always_comb begin
    sel_rdata_s = {DW{1'b0}};
    for (int i = 0; i < NS; i++) begin
      sel_rdata_s = sel_rdata_s | (m_PRDATA[i*DW +: DW] & {DW{m_PSEL[i]}});
    end
    sel_ready_s  = |(m_PREADY & m_PSEL);
    sel_slverr_s = |(m_PSLVERR & m_PSEL);
  end

  // Transfer FSM; every output is a register written only here
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r   <= IDLE;
      s_PREADY  <= 1'b0;
      s_PRDATA  <= {DW{1'b0}};
      s_PSLVERR <= 1'b0;
      m_PADDR   <= {AW{1'b0}};
      m_PWRITE  <= 1'b0;
      m_PWDATA  <= {DW{1'b0}};
      m_PENABLE <= 1'b0;
      m_PPROT   <= {PROT_W{1'b0}};
      m_PSTRB   <= {(DW/8){1'b0}};
      m_PSEL    <= {NS{1'b0}};
`ifdef APB_SPLITTER_TIMEOUT_EN
      to_cnt_r  <= {TOW{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          s_PREADY  <= 1'b0;
          s_PRDATA  <= {DW{1'b0}};
          s_PSLVERR <= 1'b0;
          if (s_PSEL && s_PENABLE) begin
            m_PADDR  <= (AM != 0) ? (s_PADDR - base_sel_s) : s_PADDR;
            m_PWRITE <= s_PWRITE;
            m_PWDATA <= s_PWDATA;
            m_PPROT  <= s_PPROT;
            m_PSTRB  <= s_PSTRB;
            if (dec_miss_s) begin
              state_r   <= RESP;
              s_PREADY  <= 1'b1;
              s_PSLVERR <= 1'b1;
            end else begin
              state_r <= M_SETUP;
              m_PSEL  <= dec_hit_s;
            end
          end
        end
        M_SETUP: begin
          m_PENABLE <= 1'b1;
          state_r   <= M_ACCESS;
`ifdef APB_SPLITTER_TIMEOUT_EN
          to_cnt_r  <= {TOW{1'b0}};
`endif
        end
        M_ACCESS: begin
          if (sel_ready_s) begin
            m_PSEL    <= {NS{1'b0}};
            m_PENABLE <= 1'b0;
            s_PREADY  <= 1'b1;
            s_PRDATA  <= m_PWRITE ? {DW{1'b0}} : sel_rdata_s;
            s_PSLVERR <= sel_slverr_s;
            state_r   <= RESP;
          end
`ifdef APB_SPLITTER_TIMEOUT_EN
          else if (to_cnt_r == TO_LAST) begin
            m_PSEL    <= {NS{1'b0}};
            m_PENABLE <= 1'b0;
            s_PREADY  <= 1'b1;
            s_PRDATA  <= {DW{1'b0}};
            s_PSLVERR <= 1'b1;
            state_r   <= RESP;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
`endif
        end
        RESP: begin
          s_PREADY  <= 1'b0;
          s_PRDATA  <= {DW{1'b0}};
          s_PSLVERR <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
